// File: rtl/quad_odometer_if.sv
// rtl/quad_odometer_if.sv - encoder inputs and odometry outputs of quad_odometer
interface quad_odometer_if;
  logic        enc_A;
  logic        enc_B;
  logic        clear_trace;
  logic [31:0] speed;
  logic        speed_valid;
  logic [31:0] trace;
  logic [7:0]  err_count;

  modport master (
    output enc_A, enc_B, clear_trace,
    input  speed, speed_valid, trace, err_count
  );

  modport slave (
    input  enc_A, enc_B, clear_trace,
    output speed, speed_valid, trace, err_count
  );
endinterface

// File: rtl/quad_odometer.sv
// rtl/quad_odometer.sv - quadrature decoder with position trace, windowed speed and error count
module quad_odometer #(
  parameter int unsigned WINDOW_CYCLES = 500000,
  parameter bit          INVERT        = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  quad_odometer_if.slave bus
);
  localparam int unsigned CW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  typedef enum logic {PRIME, RUN} state_e;

  state_e             state_q;
  logic [1:0]         prime_cnt_q;
  logic [1:0]         sync1_q, sync2_q, prev_q;
  logic [CW-1:0]      win_cnt_q;
  logic signed [31:0] acc_q, trace_q, speed_q;
  logic               speed_valid_q;
  logic [7:0]         err_q;

  logic               illegal;
  logic signed [1:0]  step_raw, step_v;
  logic signed [31:0] step32, acc_d, trace_d, speed_d;
  logic               terminal;

  // Gray-code walk 00->01->11->10 counts up; a two-bit jump is unresolvable
  always_comb begin
    step_raw = 2'sd0;
    illegal  = 1'b0;
    case ({prev_q, sync2_q})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_raw = 2'sd1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step_raw = -2'sd1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal  = 1'b1;
      default: step_raw = 2'sd0;
    endcase
    step_v   = INVERT ? -step_raw : step_raw;
    step32   = {{30{step_v[1]}}, step_v};
    acc_d    = acc_q + step32;
    trace_d  = (bus.clear_trace ? 32'sd0 : trace_q) + step32;
    terminal = (win_cnt_q == CW'(WINDOW_CYCLES - 1));
    if (acc_d > 32'sd32767) begin
      speed_d = 32'sd32767;
    end else if (acc_d < -32'sd32768) begin
      speed_d = -32'sd32768;
    end else begin
      speed_d = acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PRIME;
      prime_cnt_q   <= 2'd0;
      sync1_q       <= 2'b00;
      sync2_q       <= 2'b00;
      prev_q        <= 2'b00;
      win_cnt_q     <= '0;
      acc_q         <= 32'sd0;
      trace_q       <= 32'sd0;
      speed_q       <= 32'sd0;
      speed_valid_q <= 1'b0;
      err_q         <= 8'd0;
    end else begin
      sync1_q       <= {bus.enc_A, bus.enc_B};
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      speed_valid_q <= 1'b0;
      case (state_q)
        PRIME: begin
          // let the synchronizer and history fill before trusting transitions
          prime_cnt_q <= prime_cnt_q + 2'd1;
          if (prime_cnt_q == 2'd2) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          trace_q <= trace_d;
          if (illegal && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
          end
          if (terminal) begin
            win_cnt_q     <= '0;
            acc_q         <= 32'sd0;
            speed_q       <= speed_d;
            speed_valid_q <= 1'b1;
          end else begin
            win_cnt_q <= win_cnt_q + CW'(1);
            acc_q     <= acc_d;
          end
        end
        default: state_q <= PRIME;
      endcase
    end
  end

  assign bus.speed       = speed_q;
  assign bus.speed_valid = speed_valid_q;
  assign bus.trace       = trace_q;
  assign bus.err_count   = err_q;
endmodule

// File: tb/tb_quad_odometer.sv
// tb/tb_quad_odometer.sv - directed-vector bench for quad_odometer
module tb_quad_odometer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ea  = 1'b1;
  logic eb  = 1'b1;
  logic clr = 1'b0;
  int   ph  = 2;
  int   n_checks = 0;
  int   n_errors = 0;
  int   nvalid   = 0;
  logic [31:0] first_speed = 32'h0;
  int   seen;

  always #5 clk = ~clk;

  quad_odometer_if ia ();
  quad_odometer_if ib ();
  quad_odometer_if ic ();

  assign ia.enc_A = ea;  assign ia.enc_B = eb;  assign ia.clear_trace = clr;
  assign ib.enc_A = ea;  assign ib.enc_B = eb;  assign ib.clear_trace = clr;
  assign ic.enc_A = ea;  assign ic.enc_B = eb;  assign ic.clear_trace = clr;

  quad_odometer #(.WINDOW_CYCLES(100),   .INVERT(1'b0)) dut_a (.clk(clk), .reset(rst), .bus(ia.slave));
  quad_odometer #(.WINDOW_CYCLES(100),   .INVERT(1'b1)) dut_b (.clk(clk), .reset(rst), .bus(ib.slave));
  quad_odometer #(.WINDOW_CYCLES(40000), .INVERT(1'b0)) dut_c (.clk(clk), .reset(rst), .bus(ic.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] pat(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // move the encoder dir phases, then hold; records speed_valid pulses of dut_a
  task automatic move(input int dir, input int hold);
    ph = (ph + dir + 4) % 4;
    {ea, eb} = pat(ph);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ia.speed_valid) begin
        if (nvalid == 0) first_speed = ia.speed;
        nvalid++;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_trace", ia.trace, 32'h0);
    check("rst_speed", ia.speed, 32'h0);
    check("rst_valid", {31'h0, ia.speed_valid}, 32'h0);
    check("rst_err",   {24'h0, ia.err_count}, 32'h0);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    check("prime_11_err",   {24'h0, ia.err_count}, 32'h0);
    check("prime_11_trace", ia.trace, 32'h0);

    for (int i = 0; i < 40; i++) move(1, 10);
    check("fwd_trace",       ia.trace, 32'd40);
    check("fwd_trace_inv",   ib.trace, -32'sd40);
    check("fwd_err",         {24'h0, ia.err_count}, 32'h0);
    check("fwd_first_speed", first_speed, 32'd10);
    check("fwd_nvalid",      nvalid, 32'd4);
    check("fwd_speed_inv",   ib.speed, 32'hFFFF_FFF6);

    for (int i = 0; i < 15; i++) move(-1, 10);
    check("rev_trace",     ia.trace, 32'd25);
    check("rev_trace_inv", ib.trace, -32'sd25);
    check("rev_speed",     ia.speed, 32'hFFFF_FFF6);

    move(1, 2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_trace",     ia.trace, 32'd1);
    check("clr_trace_inv", ib.trace, -32'sd1);
    check("clr_speed",     ia.speed, 32'hFFFF_FFF6);
    repeat (47) @(negedge clk);
    check("clr_win_speed",     ia.speed, 32'hFFFF_FFFC);
    check("clr_win_speed_inv", ib.speed, 32'd4);

    for (int i = 0; i < 10; i++) move(2, 2);
    repeat (4) @(negedge clk);
    check("ill_err_10", {24'h0, ia.err_count}, 32'd10);
    for (int i = 0; i < 290; i++) move(2, 2);
    repeat (4) @(negedge clk);
    check("ill_err_sat",     {24'h0, ia.err_count}, 32'd255);
    check("ill_err_sat_inv", {24'h0, ib.err_count}, 32'd255);
    check("ill_trace",       ia.trace, 32'd1);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_err",   {24'h0, ia.err_count}, 32'h0);
    check("rst2_trace", ib.trace, 32'h0);
    check("rst2_speed", ia.speed, 32'h0);
    rst = 1'b0;

    seen = 0;
    for (int i = 0; i < 45000 && seen == 0; i++) begin
      move(1, 1);
      if (ic.speed_valid) seen = 1;
    end
    check("sat_pos_seen",  seen, 32'd1);
    check("sat_pos_speed", ic.speed, 32'h0000_7FFF);
    seen = 0;
    for (int i = 0; i < 41000 && seen == 0; i++) begin
      move(-1, 1);
      if (ic.speed_valid) seen = 1;
    end
    check("sat_neg_seen",  seen, 32'd1);
    check("sat_neg_speed", ic.speed, 32'hFFFF_8000);
    check("sat_err",       {24'h0, ic.err_count}, 32'h0);
    for (int i = 0; i < 500; i++) move(-1, 1);

    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_speed", ic.speed, 32'h0);
    check("mid_rst_trace", ic.trace, 32'h0);
    check("mid_rst_valid", {31'h0, ic.speed_valid}, 32'h0);
    check("mid_rst_err",   {24'h0, ic.err_count}, 32'h0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 102; i++) begin
      @(negedge clk);
      if (ia.speed_valid) seen++;
    end
    check("post_rst_silent", seen, 32'd0);
    @(negedge clk);
    check("post_rst_valid", {31'h0, ia.speed_valid}, 32'd1);
    check("post_rst_speed", ia.speed, 32'h0);
    check("post_rst_err",   {24'h0, ia.err_count}, 32'h0);
    check("post_rst_trace", ia.trace, 32'h0);
    @(negedge clk);
    check("valid_one_cycle", {31'h0, ia.speed_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
